addsub_chunk_seq: RTL

Multi-cycle adder-subtractor front end: takes one operand pair per transaction over a valid/ready handshake, then computes a WIDTH-bit add or subtract CHUNK bits per clock. A registered carry links the chunks. Sits directly upstream of the full-adder datapath: it sequences operands into a narrow ripple adder built from the existing full-adder cell, and presents the registered result and flags to downstream consumers. This replaces a full-width combinational ripple chain where timing does not close.

---
 rtl/addsub_pkg.sv | 19 +
 rtl/addsub_chunk_seq_if.sv | 28 ++
 rtl/addsub_chunk_seq_chunk_adder.sv | 37 +++
 rtl/addsub_chunk_seq.sv | 119 +++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and configuration helpers for the chunked adder-subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Checked at elaboration by every user of the package parameters.
  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/addsub_chunk_seq_if.sv
// Operand/result bus of the chunked adder-subtractor.
// Handshake: a transfer happens on a rising edge where valid & ready are both 1;
// the producer holds its payload stable while valid is 1 and ready is 0.
interface addsub_chunk_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/addsub_chunk_seq_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from single-bit full-adder cells.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);
  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[CHUNK];
endmodule

// File: rtl/addsub_chunk_seq.sv
// Sequenced WIDTH-bit add/subtract: one CHUNK-bit slice per clock through a
// single chunk_adder, carry linked through carry_q, registered result/flags.
module addsub_chunk_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  addsub_chunk_seq_if.slave    bus,
  output state_t               dbg_state
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = $clog2(NCHUNK) + 1;

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("addsub_chunk_seq: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q, b_q, result_q, result_upd;
  logic             carry_q, carry_out_q, overflow_q, zero_q;
  logic             in_ready_c, out_valid_c, accept, last;
  logic [CHUNK-1:0] a_ch, b_ch, sum_ch;
  logic             cout_ch;

  // Slice selection and write-back for the chunk addressed by idx_q.
  always_comb begin
    a_ch       = '0;
    b_ch       = '0;
    result_upd = result_q;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IW'(i)) begin
        a_ch                          = a_q[i*CHUNK +: CHUNK];
        b_ch                          = b_q[i*CHUNK +: CHUNK];
        result_upd[i*CHUNK +: CHUNK]  = sum_ch;
      end
    end
  end

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a   (a_ch),
    .b   (b_ch),
    .cin (carry_q),
    .sum (sum_ch),
    .cout(cout_ch)
  );

  assign last = (idx_q == IW'(NCHUNK - 1));

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        // Never advertise readiness while reset is being applied.
        in_ready_c = rst_n;
        if (bus.in_valid && rst_n) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_ready_c & bus.in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
      a_q      <= bus.a;
      b_q      <= bus.sub ? ~bus.b : bus.b;
      carry_q  <= bus.sub;
      idx_q    <= '0;
      result_q <= '0;
    end else if (state_q == RUN) begin
      result_q <= result_upd;
      carry_q  <= cout_ch;
      idx_q    <= idx_q + IW'(1);
      if (last) begin
        carry_out_q <= cout_ch;
        overflow_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &
                       (result_upd[WIDTH-1] != a_q[WIDTH-1]);
        zero_q      <= (result_upd == '0);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign dbg_state     = state_q;

endmodule
